// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - byte/half/word load-store controller for a word-addressed DataMemory
// Optional upper-address bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_access_unit #(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 store,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [dataWidth-1:0] addr,
  input  logic [dataWidth-1:0] wdata,
  output logic [dataWidth-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_we,
  output logic [dataWidth-1:0] mem_addr,
  output logic [dataWidth-1:0] mem_di,
  input  logic [dataWidth-1:0] mem_do
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t               state, state_nx;
  logic [1:0]           lane_q;
  logic                 store_q;
  logic [1:0]           size_q;
  logic                 sign_ext_q;
  logic [dataWidth-1:0] wdata_q;
  logic                 err_q;
  logic [dataWidth-1:0] word_q;
  logic                 bad;
  logic [4:0]           sh;
  logic [dataWidth-1:0] rd_shifted;
  logic [dataWidth-1:0] load_val;
  logic [dataWidth-1:0] lane_mask;
  logic [dataWidth-1:0] lane_data;
  logic [dataWidth-1:0] merged;

  always_comb begin
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    if (|addr[dataWidth-1:addWidth+2]) bad = 1'b1;
`endif
  end

  assign sh         = {lane_q, 3'b000};
  assign rd_shifted = mem_do >> sh;

  always_comb begin
    load_val = mem_do;
    case (size_q)
      2'b00:   load_val = sign_ext_q ? {{(dataWidth-8){rd_shifted[7]}}, rd_shifted[7:0]}
                                     : {{(dataWidth-8){1'b0}}, rd_shifted[7:0]};
      2'b01:   load_val = sign_ext_q ? {{(dataWidth-16){rd_shifted[15]}}, rd_shifted[15:0]}
                                     : {{(dataWidth-16){1'b0}}, rd_shifted[15:0]};
      default: load_val = mem_do;
    endcase
  end

  // Sub-word stores splice the new lane(s) into the word read during RD.
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    merged    = wdata_q;
    case (size_q)
      2'b00: begin
        lane_mask = {{(dataWidth-8){1'b0}}, 8'hFF} << sh;
        lane_data = {{(dataWidth-8){1'b0}}, wdata_q[7:0]} << sh;
        merged    = (word_q & ~lane_mask) | lane_data;
      end
      2'b01: begin
        lane_mask = {{(dataWidth-16){1'b0}}, 16'hFFFF} << sh;
        lane_data = {{(dataWidth-16){1'b0}}, wdata_q[15:0]} << sh;
        merged    = (word_q & ~lane_mask) | lane_data;
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_di   = '0;
    case (state)
      IDLE: if (req) state_nx = bad ? DONE : ((!store || size != 2'b10) ? RD : WR);
      RD:   state_nx = store_q ? WR : DONE;
      WR: begin
        // A reset landing on the write edge must not corrupt memory.
        mem_we   = !reset;
        mem_di   = merged;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign err = done & err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lane_q     <= '0;
      store_q    <= 1'b0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      word_q     <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        lane_q     <= addr[1:0];
        store_q    <= store;
        size_q     <= size;
        sign_ext_q <= sign_ext;
        wdata_q    <= wdata;
        err_q      <= bad;
        mem_addr   <= {2'b00, addr[dataWidth-1:2]};
      end
      if (state == RD) begin
        word_q <= mem_do;
        if (!store_q) rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed and randomized bench for dmem_access_unit against a byte-level model
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rdata;
  logic        init_mem;
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.addWidth(6), .dataWidth(32)) dut (
    .clk(clk), .reset(reset), .req(req), .store(store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .err(err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  assign mem_do = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h5A00_0000 + 32'(i);
    end else if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_di;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic access(input bit st, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit          e;
    int          lat, exp_we, n, we_cnt, lane, nbytes;
    bit          got;
    logic [5:0]  idx;
    logic [31:0] w, v;
    idx  = a[7:2];
    lane = int'(a[1:0]);
    e    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (a[31:8] != 24'd0) e = 1'b1;
`endif
    if (e) lat = 1;
    else if (!st || sz == 2'd2) lat = 2;
    else lat = 3;
    exp_we = (st && !e) ? 1 : 0;
    if (!e) begin
      w = ref_mem[idx];
      if (!st) begin
        v = w >> (8 * lane);
        if (sz == 2'd0) begin
          v = v & 32'hFF;
          if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = v & 32'hFFFF;
          if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        exp_rdata = v;
      end else begin
        nbytes = 1 << sz;
        for (int b = 0; b < 4; b++)
          if (b >= lane && b < lane + nbytes) w[8*b +: 8] = wd[8*(b-lane) +: 8];
        ref_mem[idx] = w;
      end
    end

    @(negedge clk);
    req = 1'b1; store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    n = 0; we_cnt = 0; got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      req = 1'b0;
      if (mem_we) we_cnt++;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " err"}, 32'(err), 32'(e));
    check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " we_cycles"}, 32'(we_cnt), 32'(exp_we));
    check({tag, " row"}, mem[idx], ref_mem[idx]);
    @(negedge clk);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, hi;
    bit          no_done;
    reset = 1'b1; req = 1'b0; store = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0; init_mem = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h5A00_0000 + 32'(i);
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_di", mem_di, 32'd0);
    check("reset rdata", rdata, 32'd0);
    reset = 1'b0;

    preload(6'd1, 32'h8070_6050);
    preload(6'd2, 32'h1122_3344);
    access(1'b0, 2'd0, 1'b1, 32'h5, '0, "lb_sx_a5");
    check("lb_sx_a5 value", rdata, 32'h0000_0060);
    access(1'b0, 2'd0, 1'b1, 32'h7, '0, "lb_sx_a7");
    check("lb_sx_a7 value", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'd1, 1'b0, 32'h6, '0, "lhu_a6");
    check("lhu_a6 value", rdata, 32'h0000_8070);
    access(1'b0, 2'd1, 1'b1, 32'h6, '0, "lh_a6");
    check("lh_a6 value", rdata, 32'hFFFF_8070);
    access(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AB, "sb_a9");
    check("sb_a9 row2", mem[2], 32'h1122_AB44);
    access(1'b1, 2'd2, 1'b0, 32'h2, 32'h1234_5678, "sw_mis_a2");
    check("sw_mis_a2 row0", mem[0], 32'h5A00_0000);
    access(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, "sw_a8");
    check("sw_a8 row2", mem[2], 32'hDEAD_BEEF);
    access(1'b0, 2'd3, 1'b0, 32'h4, '0, "illegal_size");
    access(1'b0, 2'd1, 1'b0, 32'h5, '0, "lh_mis_a5");
    access(1'b0, 2'd2, 1'b0, 32'h100, '0, "lw_a100");

    // Reset during the WR cycle of a byte store: no write, no done.
    access(1'b0, 2'd2, 1'b0, 32'hC, '0, "lw_row3");
    @(negedge clk);
    req = 1'b1; store = 1'b1; size = 2'd0; addr = 32'hD; wdata = 32'h0000_00EE;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_wr in_wr", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wr mem_we", 32'(mem_we), 32'd0);
    check("rst_wr busy", 32'(busy), 32'd0);
    check("rst_wr rdata", rdata, 32'd0);
    exp_rdata = '0;
    reset = 1'b0;
    no_done = 1'b1;
    repeat (4) begin
      if (done) no_done = 1'b0;
      @(negedge clk);
    end
    check("rst_wr no_done", 32'(no_done), 32'd1);
    check("rst_wr row3", mem[3], ref_mem[3]);

    // req and reset on the same edge: request dropped.
    reset = 1'b1; req = 1'b1; store = 1'b0; size = 2'd2; addr = 32'h4;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    check("rst_req busy", 32'(busy), 32'd0);
    no_done = 1'b1;
    repeat (3) begin
      if (done || busy) no_done = 1'b0;
      @(negedge clk);
    end
    check("rst_req quiet", 32'(no_done), 32'd1);

    for (int k = 0; k < 40; k++) begin
      ra = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        hi = $urandom;
        ra[31:8] = hi[23:0];
      end
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ra, $urandom, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator-side load/store controller between the MIPS datapath and the word-addressed DataMemory (async read, sync write, one 32-bit word per row).
- Turns byte, halfword and word loads and stores into memory cycles. Sub-word stores use read-modify-write.
- Does sign/zero extension and alignment checking.
- Uses a req/done handshake so the pipeline can stall on busy.

Parameters:
- addWidth, 6, log2 of the memory depth in words (64 words).
- dataWidth, 32, word width. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- req  input  1  access request; sampled only in IDLE.
- store  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word. 11 is treated as an error.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  dataWidth  byte address.
- wdata  input  dataWidth  store data, right-justified.
- rdata  output  dataWidth  load result, extended.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done: misaligned access or illegal size.
- mem_we  output  1  DataMemory write enable.
- mem_addr  output  dataWidth  DataMemory row index = {2'b00, addr_q[31:2]}.
- mem_di  output  dataWidth  DataMemory write data.
- mem_do  input  dataWidth  DataMemory read data; combinational from mem_addr.

Behaviour:
- Byte lanes are little-endian: byte n of a word is bits [8n+7:8n]. The lane is selected by addr[1:0].
- States: IDLE, RD, WR, DONE.
- IDLE, on req:
  - Latch addr, store, size, sign_ext and wdata into *_q registers.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11, set err_q and go to DONE. No memory access occurs.
  - Else a load or a byte/half store goes to RD.
  - Else a word store goes to WR.
- RD:
  - mem_we=0.
  - Capture mem_do into word_q.
  - Load goes to DONE. Store goes to WR.
- WR:
  - mem_we=1.
  - Word store: mem_di = wdata_q.
  - Byte/half store: mem_di = word_q with only the addressed lane(s) replaced by wdata_q[7:0] or wdata_q[15:0]. Other bytes are preserved.
  - Next state is DONE.
- DONE:
  - done=1 and err=err_q for this cycle.
  - For a successful load, rdata updates at the RD->DONE edge: the selected byte/half/word, extended per sign_ext_q.
  - Next state is IDLE.
- Latency, counted as edges from the req-sampling edge to done high:
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
  - Error: 1.
- Throughput: a new req is accepted in the IDLE cycle that follows DONE. req while busy is ignored and not queued.
- mem_addr is registered: it holds addr_q's word index from acceptance until the next acceptance. mem_we is high only in WR.
- rdata holds its value until the next successful load. Stores and errors leave rdata unchanged.
- Reset:
  - Takes effect at the rising edge: state <- IDLE.
  - rdata, done, err, busy, mem_we, mem_addr and mem_di <- 0.
  - Reset asserted during RD or WR: no write occurs after that edge, and no done is issued.
- req and reset high on the same edge: reset wins and the request is dropped.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: if addr[31:addWidth+2] != 0, the access is treated like a misaligned access: IDLE -> DONE with err=1, mem_we never asserted.
- Undefined: upper address bits are not checked. mem_addr carries the full index, and DataMemory aliases it.

Test Plan:
- Preload row 1 = 32'h8070_6050. Load byte, addr=32'h5, sign_ext=1 -> done 2 edges after req, rdata=32'h0000_0060, err=0. Same access at addr=32'h7 -> rdata=32'hFFFF_FF80.
- Load half, addr=32'h6, sign_ext=0 on the same row -> rdata=32'h0000_8070. With sign_ext=1 -> 32'hFFFF_8070.
- Store byte, addr=32'h9, wdata=32'h0000_00AB, row 2 preset 32'h1122_3344 -> exactly one mem_we cycle (WR), row 2 = 32'h1122_AB44, done 3 edges after req.
- Store word, addr=32'h2 -> done with err=1 1 edge after req, mem_we never high, memory unchanged. Store word at addr=32'h8 with wdata=32'hDEAD_BEEF -> row 2 = 32'hDEAD_BEEF, done after 2 edges.
- Assert reset during WR of a byte store -> mem_we=0 and busy=0 after that edge, no done pulse, target row unchanged.
- With DMEM_BOUNDS_CHECK_EN: load word at addr=32'h100 -> err=1, no memory access. Without the macro: reads row 0.
